icache_assoc: RTL and testbench

Parametrised set-associative instruction cache sitting between the pre-IF stage and the instruction-side memory port. It is the successor to the direct-mapped 512-byte icache. Ways, sets, line size and memory beat width are configurable, and it adds per-line valid bits, victim selection and a whole-cache invalidate for `fence.i`. A refill fetches a full line as a sequence of beats, installs it, and returns to lookup so that the held request hits.

---
 rtl/icache_assoc.sv | 212 +++++++++++++++++++++
 tb/tb_icache_assoc.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_assoc.sv
// Set-associative instruction cache between pre-IF and the instruction memory port.
// Misses refill a whole line beat by beat, install it, then replay the held lookup.
module icache_assoc #(
    parameter int ADDR_W     = 32,
    parameter int BEAT_W     = 64,
    parameter int WAYS       = 2,
    parameter int SETS       = 16,
    parameter int LINE_BYTES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   preif_raddr_i,
    input  logic                preif_raddr_valid_i,
    input  logic                invalidate_i,
    output logic [63:0]         if_rdata_o,
    output logic                if_rdata_valid_o,
    output logic                busy_o,
    output logic [ADDR_W-1:0]   ram_raddr_icache_o,
    output logic                ram_raddr_valid_icache_o,
    output logic [BEAT_W/8-1:0] ram_rmask_icache_o,
    input  logic                ram_rdata_ready_icache_i,
    input  logic [BEAT_W-1:0]   ram_rdata_icache_i
);
    localparam int OFF        = $clog2(LINE_BYTES);
    localparam int IDX        = $clog2(SETS);
    localparam int TAG        = ADDR_W - IDX - OFF;
    localparam int BEATS      = LINE_BYTES * 8 / BEAT_W;
    localparam int LINE_W     = LINE_BYTES * 8;
    localparam int BEAT_BYTES = BEAT_W / 8;
    localparam int WPL        = LINE_BYTES / 4;
    localparam int WORD_W     = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, INVAL} state_e;

    state_e                          state_q, state_d;
    logic [WAYS-1:0][SETS-1:0]       valid_q, valid_d;
    logic [SETS-1:0][WAY_W-1:0]      ptr_q, ptr_d;
    logic [TAG-1:0]                  req_tag_q, req_tag_d;
    logic [IDX-1:0]                  req_idx_q, req_idx_d;
    logic [BEAT_CNT_W-1:0]           beat_q, beat_d;
    logic [WAY_W-1:0]                victim_q, victim_d;
    logic                            from_ptr_q, from_ptr_d;
    logic                            pend_q, pend_d;
    logic [31:0]                     rdata_q, rdata_d;
    logic                            rdata_valid_q, rdata_valid_d;
    logic [LINE_W-1:0]               fill_q, fill_d;
    logic [TAG-1:0]                  tag_q  [WAYS][SETS];
    logic [LINE_W-1:0]               line_q [WAYS][SETS];
    logic                            install;

    logic [TAG-1:0]    a_tag;
    logic [IDX-1:0]    a_idx;
    logic [WORD_W-1:0] a_word;
    logic [WAYS-1:0]   hit_vec;
    logic [WAY_W-1:0]  hit_way;
    logic              hit;
    logic [31:0]       hit_word;
    logic              inv_any;
    logic [WAY_W-1:0]  inv_way;
    logic              unused_addr_bits;

    assign a_tag            = preif_raddr_i[ADDR_W-1:OFF+IDX];
    assign a_idx            = preif_raddr_i[OFF+IDX-1:OFF];
    assign unused_addr_bits = ^preif_raddr_i[1:0];

    generate
        if (WPL > 1) begin : g_word
            assign a_word = preif_raddr_i[OFF-1:2];
        end else begin : g_one_word
            assign a_word = '0;
        end
    endgenerate

    // NOTE: every variable written in a combinational block gets a default first, so no latch can form.
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][a_idx] && tag_q[w][a_idx] == a_tag) begin
                hit_vec[w] = 1'b1;
                hit_way    = WAY_W'(w);
            end
        end
        // Scanning downwards leaves the lowest-numbered empty way selected.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][a_idx]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    assign hit      = |hit_vec;
    assign hit_word = line_q[hit_way][a_idx][a_word*32 +: 32];

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        ptr_d         = ptr_q;
        req_tag_d     = req_tag_q;
        req_idx_d     = req_idx_q;
        beat_d        = beat_q;
        victim_d      = victim_q;
        from_ptr_d    = from_ptr_q;
        pend_d        = pend_q;
        fill_d        = fill_q;
        rdata_d       = '0;
        rdata_valid_d = 1'b0;
        install       = 1'b0;
        case (state_q)
            IDLE: begin
                if (invalidate_i) begin
                    state_d = INVAL;
                end else if (preif_raddr_valid_i) begin
                    if (hit) begin
                        rdata_d       = hit_word;
                        rdata_valid_d = 1'b1;
                    end else begin
                        req_tag_d  = a_tag;
                        req_idx_d  = a_idx;
                        beat_d     = '0;
                        victim_d   = inv_any ? inv_way : ptr_q[a_idx];
                        from_ptr_d = !inv_any;
                        state_d    = REFILL;
                    end
                end
            end
            REFILL: begin
                if (invalidate_i) pend_d = 1'b1;
                if (ram_rdata_ready_icache_i) begin
                    fill_d[beat_q*BEAT_W +: BEAT_W] = ram_rdata_icache_i;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BEAT_CNT_W'(BEATS - 1)) state_d = WRITE;
                end
            end
            WRITE: begin
                // A fence arriving in this very cycle must also discard the line.
                if (pend_q || invalidate_i) begin
                    state_d = INVAL;
                end else begin
                    install                      = 1'b1;
                    valid_d[victim_q][req_idx_q] = 1'b1;
                    if (from_ptr_q) begin
                        ptr_d[req_idx_q] = (ptr_q[req_idx_q] == WAY_W'(WAYS - 1)) ?
                                           '0 : ptr_q[req_idx_q] + 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            INVAL: begin
                valid_d = '0;
                pend_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            ptr_q         <= '0;
            req_tag_q     <= '0;
            req_idx_q     <= '0;
            beat_q        <= '0;
            victim_q      <= '0;
            from_ptr_q    <= 1'b0;
            pend_q        <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            ptr_q         <= ptr_d;
            req_tag_q     <= req_tag_d;
            req_idx_q     <= req_idx_d;
            beat_q        <= beat_d;
            victim_q      <= victim_d;
            from_ptr_q    <= from_ptr_d;
            pend_q        <= pend_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    // NOTE: line, tag and fill storage carry no reset; valid bits alone decide whether contents are used.
    always_ff @(posedge clk) begin
        fill_q <= fill_d;
        if (install) begin
            line_q[victim_q][req_idx_q] <= fill_q;
            tag_q[victim_q][req_idx_q]  <= req_tag_q;
        end
    end

    assign busy_o                   = (state_q != IDLE);
    assign if_rdata_valid_o         = rdata_valid_q;
    assign if_rdata_o               = rdata_valid_q ? {32'b0, rdata_q} : 64'b0;
    assign ram_raddr_valid_icache_o = (state_q == REFILL);
    assign ram_rmask_icache_o       = ram_raddr_valid_icache_o ? '1 : '0;
    assign ram_raddr_icache_o       = {req_tag_q, req_idx_q, {OFF{1'b0}}} +
                                      ADDR_W'(beat_q) * ADDR_W'(BEAT_BYTES);

    a_single_hit: assert property (@(posedge clk) disable iff (!rst)
        (state_q == IDLE && preif_raddr_valid_i) |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_icache_assoc.sv
// Randomised scoreboard bench for icache_assoc against an abstract cache and memory model.
// Driver acts half a cycle after the rising edge; monitor and memory responder act on the falling edge.
module tb_icache_assoc;
    localparam int ADDR_W     = 32;
    localparam int BEAT_W     = 64;
    localparam int WAYS       = 2;
    localparam int SETS       = 16;
    localparam int LINE_BYTES = 16;
    localparam int BEATS      = LINE_BYTES * 8 / BEAT_W;
    localparam int BEAT_BYTES = BEAT_W / 8;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          hit;
        int          t0;
        int          exact;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [ADDR_W-1:0]     preif_raddr_i = '0;
    logic                  preif_raddr_valid_i = 1'b0;
    logic                  invalidate_i = 1'b0;
    logic [63:0]           if_rdata_o;
    logic                  if_rdata_valid_o;
    logic                  busy_o;
    logic [ADDR_W-1:0]     ram_raddr_icache_o;
    logic                  ram_raddr_valid_icache_o;
    logic [BEAT_BYTES-1:0] ram_rmask_icache_o;
    logic                  ram_rdata_ready_icache_i = 1'b0;
    logic [BEAT_W-1:0]     ram_rdata_icache_i = '0;

    icache_assoc #(
        .ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .WAYS(WAYS), .SETS(SETS), .LINE_BYTES(LINE_BYTES)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .preif_raddr_i            (preif_raddr_i),
        .preif_raddr_valid_i      (preif_raddr_valid_i),
        .invalidate_i             (invalidate_i),
        .if_rdata_o               (if_rdata_o),
        .if_rdata_valid_o         (if_rdata_valid_o),
        .busy_o                   (busy_o),
        .ram_raddr_icache_o       (ram_raddr_icache_o),
        .ram_raddr_valid_icache_o (ram_raddr_valid_icache_o),
        .ram_rmask_icache_o       (ram_rmask_icache_o),
        .ram_rdata_ready_icache_i (ram_rdata_ready_icache_i),
        .ram_rdata_icache_i       (ram_rdata_icache_i)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    int          rdy_mode = 0;
    int          beats_total = 0;
    int          beat_k = 0;
    bit          stall = 0;
    logic [31:0] stall_addr = '0;
    logic [31:0] cur_line = '0;
    exp_t        exp_q[$];

    bit          m_valid [WAYS][SETS];
    int unsigned m_tag   [WAYS][SETS];
    int          m_ptr   [SETS];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [BEAT_W-1:0] beat_data(input logic [31:0] a);
        logic [BEAT_W-1:0] d;
        for (int k = 0; k < BEAT_W / 32; k++) d[k*32 +: 32] = mem_word(a + 32'(4 * k));
        return d;
    endfunction

    task automatic model_invalidate();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) m_valid[w][s] = 1'b0;
    endtask

    task automatic model_reset();
        model_invalidate();
        for (int s = 0; s < SETS; s++) m_ptr[s] = 0;
    endtask

    // Abstract cache: per set, each way holds a tag; misses fill the first empty way, else round-robin.
    task automatic model_access(input logic [31:0] a, output bit hit);
        int unsigned idx, tg;
        int          victim;
        idx = (a / LINE_BYTES) % SETS;
        tg  = a / (LINE_BYTES * SETS);
        hit = 1'b0;
        for (int w = 0; w < WAYS; w++) if (m_valid[w][idx] && m_tag[w][idx] == tg) hit = 1'b1;
        if (!hit) begin
            victim = -1;
            for (int w = 0; w < WAYS; w++) if (!m_valid[w][idx] && victim < 0) victim = w;
            if (victim < 0) begin
                victim     = m_ptr[idx];
                m_ptr[idx] = (m_ptr[idx] + 1) % WAYS;
            end
            m_valid[victim][idx] = 1'b1;
            m_tag[victim][idx]   = tg;
        end
    endtask

    // Memory responder: drives ready/data and checks the beat handshake.
    always @(negedge clk) begin
        if (!rst) begin
            ram_rdata_ready_icache_i = 1'b0;
            beat_k = 0;
            stall  = 1'b0;
        end else begin
            bit r;
            if (stall) begin
                check("hold_req", 64'(ram_raddr_valid_icache_o), 64'd1);
                check("hold_addr", 64'(ram_raddr_icache_o), 64'(stall_addr));
            end
            case (rdy_mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = ($urandom_range(0, 2) == 0);
            endcase
            ram_rdata_ready_icache_i = r;
            ram_rdata_icache_i       = beat_data(ram_raddr_icache_o);
            if (ram_raddr_valid_icache_o) begin
                check("rmask_on", 64'(ram_rmask_icache_o), 64'({BEAT_BYTES{1'b1}}));
                if (r) begin
                    check("beat_addr", 64'(ram_raddr_icache_o), 64'(cur_line + 32'(beat_k * BEAT_BYTES)));
                    beat_k = (beat_k + 1) % BEATS;
                    beats_total++;
                end
            end else begin
                check("rmask_off", 64'(ram_rmask_icache_o), 64'd0);
            end
            stall      = ram_raddr_valid_icache_o && !r;
            stall_addr = ram_raddr_icache_o;
        end
    end

    // Response monitor: pops the scoreboard whenever the cache presents a word.
    always @(negedge clk) begin
        if (rst) begin
            if (busy_o) check("valid_while_busy", 64'(if_rdata_valid_o), 64'd0);
            if (if_rdata_valid_o) begin
                check("resp_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    int   lat;
                    e   = exp_q.pop_front();
                    lat = cyc - e.t0;
                    check("rdata", if_rdata_o, {32'b0, e.data});
                    check("hit_class", 64'(lat == 1), 64'(e.hit));
                    if (e.exact != 0) check("miss_latency", 64'(lat), 64'(e.exact));
                end
            end else begin
                check("rdata_gated", if_rdata_o, 64'd0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_resp();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            step();
            n++;
        end
        check("resp_timeout", 64'(exp_q.size() == 0), 64'd1);
        preif_raddr_valid_i = 1'b0;
        exp_q.delete();
    endtask

    // inv_mode: 0 none, 1 invalidate with the request, 2 invalidate the cycle after the miss.
    task automatic fetch(input logic [31:0] a, input int inv_mode);
        bit   h;
        exp_t e;
        if (inv_mode != 0) model_invalidate();
        model_access(a, h);
        e.addr  = a;
        e.data  = mem_word(a);
        e.hit   = h;
        e.t0    = cyc;
        e.exact = (!h && inv_mode == 0 && rdy_mode == 0) ? BEATS + 3 : 0;
        exp_q.push_back(e);
        cur_line            = a & ~32'(LINE_BYTES - 1);
        preif_raddr_i       = a;
        preif_raddr_valid_i = 1'b1;
        if (inv_mode == 1) begin
            invalidate_i = 1'b1;
            step();
            invalidate_i = 1'b0;
        end else if (inv_mode == 2) begin
            step();
            invalidate_i = 1'b1;
            step();
            invalidate_i = 1'b0;
        end
        wait_resp();
    endtask

    task automatic pulse_invalidate();
        invalidate_i = 1'b1;
        step();
        invalidate_i = 1'b0;
        model_invalidate();
        step();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int n;
        model_reset();
        repeat (3) step();
        check("rst_rdata_valid", 64'(if_rdata_valid_o), 64'd0);
        check("rst_rdata", if_rdata_o, 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_ram_valid", 64'(ram_raddr_valid_icache_o), 64'd0);
        check("rst_rmask", 64'(ram_rmask_icache_o), 64'd0);
        rst = 1'b1;
        step();

        // Cold miss, then hits on the rest of the line.
        rdy_mode = 0;
        b0 = beats_total;
        fetch(32'h8000_0000, 0);
        check("cold_beats", 64'(beats_total - b0), 64'(BEATS));
        for (int i = 1; i < 4; i++) fetch(32'h8000_0000 + 32'(4 * i), 0);

        // Same-set conflict across three tags.
        fetch(32'h8000_0100, 0);
        fetch(32'h8000_0200, 0);
        fetch(32'h8000_0104, 0);
        fetch(32'h8000_0008, 0);
        fetch(32'h8000_0204, 0);

        // Slow memory: ready every third cycle.
        rdy_mode = 1;
        for (int i = 0; i < 4; i++) fetch(32'h8000_3000 + 32'(4 * i), 0);
        fetch(32'h8000_3014, 0);
        rdy_mode = 0;

        // Fence during refill: both refills run to completion, nothing old survives.
        b0 = beats_total;
        fetch(32'h8000_2000, 2);
        check("fence_beats", 64'(beats_total - b0), 64'(2 * BEATS));
        fetch(32'h8000_0100, 0);
        fetch(32'h8000_2004, 0);

        // Fence in IDLE together with a request to a cached line.
        fetch(32'h8000_2008, 1);

        // Reset after the first beat of a refill.
        b0                  = beats_total;
        cur_line            = 32'h8000_4000;
        preif_raddr_i       = 32'h8000_4000;
        preif_raddr_valid_i = 1'b1;
        n = 0;
        while (beats_total == b0 && n < 50) begin
            step();
            n++;
        end
        check("rst_first_beat", 64'(beats_total - b0), 64'd1);
        @(posedge clk);
        #2;
        rst                 = 1'b0;
        preif_raddr_valid_i = 1'b0;
        #1;
        check("rst_async_ram_valid", 64'(ram_raddr_valid_icache_o), 64'd0);
        check("rst_async_rmask", 64'(ram_rmask_icache_o), 64'd0);
        check("rst_async_busy", 64'(busy_o), 64'd0);
        exp_q.delete();
        model_reset();
        step();
        step();
        rst = 1'b1;
        step();
        fetch(32'h8000_2000, 0);
        fetch(32'h8000_0000, 0);
        fetch(32'h8000_0100, 0);
        fetch(32'h8000_0200, 0);
        fetch(32'h8000_0100, 0);
        fetch(32'h8000_0000, 0);

        // Random fetch stream over four tags' worth of address space.
        for (int i = 0; i < 300; i++) begin
            int          r;
            logic [31:0] a;
            r        = int'($urandom_range(0, 99));
            rdy_mode = int'($urandom_range(0, 2));
            a        = 32'h8000_0000 + 32'($urandom_range(0, 4 * SETS * LINE_BYTES / 4 - 1) * 4)
                       + 32'($urandom_range(0, 3));
            if (r < 4) pulse_invalidate();
            fetch(a, (r >= 4 && r < 7) ? 1 : 0);
        end

        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
